// File: rtl/mem_line_arbiter.sv
// Shares one single-word memory port between the I-cache refill and the D-cache
// refill/writeback engines, running each grant as a LINE_WORDS-word burst.
module mem_line_arbiter #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int IDX_BITS   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // I-side refill requester
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_grant,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_valid,
    output logic [IDX_BITS-1:0]  i_idx,
    output logic                 i_done,
    // D-side refill / writeback requester
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_grant,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_valid,
    output logic [IDX_BITS-1:0]  d_idx,
    output logic                 d_done,
    // memory port
    output logic                 m_read,
    output logic                 m_write,
    output logic [WORD_SIZE-1:0] m_addr,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    input  logic                 m_inputReady,
    input  logic                 m_ackOutput
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_I    = 3'd1,
        SERVE_D_RD = 3'd2,
        SERVE_D_WR = 3'd3,
        DONE       = 3'd4
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    localparam logic [WORD_SIZE-1:0] LINE_MASK = ~WORD_SIZE'(LINE_WORDS - 1);
    localparam logic [IDX_BITS-1:0]  LAST_IDX  = IDX_BITS'(LINE_WORDS - 1);

    state_t                state, state_nxt;
    side_t                 last_grant, last_grant_nxt;
    side_t                 done_side, done_side_nxt;
    logic [WORD_SIZE-1:0]  base, base_nxt;
    logic [IDX_BITS-1:0]   idx, idx_nxt;
    logic                  wait_q, wait_nxt;
    logic [WORD_SIZE-1:0]  i_rdata_q, d_rdata_q;

    logic serve_i, serve_d, serving, reading, handshake, word_done;

    assign serve_i   = (state == SERVE_I);
    assign serve_d   = (state == SERVE_D_RD) || (state == SERVE_D_WR);
    assign serving   = serve_i || serve_d;
    assign reading   = (state == SERVE_I) || (state == SERVE_D_RD);
    assign handshake = reading ? m_inputReady : m_ackOutput;
    // The memory holds its handshake high after finishing a word, so a
    // completion is only believed once the current address has been up a cycle.
    assign word_done = serving && wait_q && handshake;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        done_side_nxt  = done_side;
        base_nxt       = base;
        idx_nxt        = idx;
        wait_nxt       = wait_q;
        case (state)
            IDLE: begin
                wait_nxt = 1'b0;
                idx_nxt  = '0;
                if (i_req && (!d_req || last_grant == SIDE_D)) begin
                    state_nxt      = SERVE_I;
                    base_nxt       = i_addr & LINE_MASK;
                    last_grant_nxt = SIDE_I;
                end else if (d_req) begin
                    state_nxt      = d_we ? SERVE_D_WR : SERVE_D_RD;
                    base_nxt       = d_addr & LINE_MASK;
                    last_grant_nxt = SIDE_D;
                end
            end
            SERVE_I, SERVE_D_RD, SERVE_D_WR: begin
                if (word_done) begin
                    wait_nxt = 1'b0;
                    if (idx == LAST_IDX) begin
                        state_nxt     = DONE;
                        done_side_nxt = serve_i ? SIDE_I : SIDE_D;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    wait_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= SIDE_I;
            done_side  <= SIDE_I;
            base       <= '0;
            idx        <= '0;
            wait_q     <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            done_side  <= done_side_nxt;
            base       <= base_nxt;
            idx        <= idx_nxt;
            wait_q     <= wait_nxt;
            if (i_valid)
                i_rdata_q <= m_rdata;
            if (d_valid && state == SERVE_D_RD)
                d_rdata_q <= m_rdata;
        end
    end

    // Returned data is visible in the completion cycle and held afterwards.
    assign i_grant = serve_i;
    assign i_valid = serve_i && word_done;
    assign i_idx   = serve_i ? idx : '0;
    assign i_rdata = i_valid ? m_rdata : i_rdata_q;
    assign i_done  = (state == DONE) && (done_side == SIDE_I);

    assign d_grant = serve_d;
    assign d_valid = serve_d && word_done;
    assign d_idx   = serve_d ? idx : '0;
    assign d_rdata = (d_valid && state == SERVE_D_RD) ? m_rdata : d_rdata_q;
    assign d_done  = (state == DONE) && (done_side == SIDE_D);

    assign m_read  = reading;
    assign m_write = (state == SERVE_D_WR);
    assign m_addr  = serving ? (base | WORD_SIZE'(idx)) : '0;
    assign m_wdata = m_write ? d_wdata : '0;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter: latency memory model with sticky
// handshakes, per-side queues of expected words popped as words are delivered.
module tb_mem_line_arbiter;
    localparam int W  = 16;
    localparam int IB = 2;
    localparam logic [W-1:0] WDATA_BASE = 16'h1000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          i_req = 1'b0;
    logic [W-1:0]  i_addr = '0;
    logic          i_grant, i_valid, i_done;
    logic [W-1:0]  i_rdata;
    logic [IB-1:0] i_idx;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [W-1:0]  d_addr = '0;
    logic [W-1:0]  d_wdata;
    logic          d_grant, d_valid, d_done;
    logic [W-1:0]  d_rdata;
    logic [IB-1:0] d_idx;
    logic          m_read, m_write;
    logic [W-1:0]  m_addr, m_wdata;
    logic [W-1:0]  m_rdata = '0;
    logic          m_inputReady = 1'b0;
    logic          m_ackOutput = 1'b0;

    always #5 clk = ~clk;

    // The D requester supplies write data for whatever word index is current.
    assign d_wdata = WDATA_BASE + W'(d_idx);

    mem_line_arbiter #(.WORD_SIZE(W), .LINE_WORDS(4), .IDX_BITS(IB)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_rdata(i_rdata),
        .i_valid(i_valid), .i_idx(i_idx), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_rdata(d_rdata), .d_valid(d_valid), .d_idx(d_idx),
        .d_done(d_done),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_inputReady(m_inputReady), .m_ackOutput(m_ackOutput)
    );

    // Memory: new address restarts a countdown of 'lat' cycles while the old
    // handshake is left standing; completion raises and holds the handshake.
    logic [W-1:0] mem [0:255];
    logic         mem_init = 1'b0;
    int           lat = 2;
    int           cnt = 0;
    logic         act = 1'b0;
    logic [W-1:0] cur = '0;

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 256; a++) mem[a] = 16'hB000 + 16'(a * 7);
            mem_init = 1'b1;
        end
        if (m_read || m_write) begin
            if (!act || m_addr != cur) begin
                cur = m_addr;
                cnt = lat;
            end else if (cnt > 0) begin
                cnt--;
                m_inputReady = 1'b0;
                m_ackOutput  = 1'b0;
            end else if (m_read) begin
                m_rdata      = mem[m_addr[7:0]];
                m_inputReady = 1'b1;
            end else begin
                mem[m_addr[7:0]] = m_wdata;
                m_ackOutput      = 1'b1;
            end
            act = 1'b1;
        end else begin
            act = 1'b0;
        end
    end

    typedef struct {
        logic          wr;
        logic [IB-1:0] idx;
        logic [W-1:0]  addr;
        logic [W-1:0]  data;
    } exp_t;

    exp_t         exp_i[$];
    exp_t         exp_d[$];
    logic [W-1:0] img [0:255];
    logic         done_log[$];
    int           i_vcnt = 0, d_vcnt = 0, i_dcnt = 0, d_dcnt = 0;
    int           errors = 0, checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic push_line(input logic side_d, input logic wr, input logic [W-1:0] addr);
        exp_t         e;
        logic [W-1:0] base;
        base = addr & 16'hFFFC;
        for (int k = 0; k < 4; k++) begin
            e.wr   = wr;
            e.idx  = IB'(k);
            e.addr = base + W'(k);
            if (wr) begin
                e.data = WDATA_BASE + W'(k);
                img[e.addr[7:0]] = e.data;
            end else begin
                e.data = img[e.addr[7:0]];
            end
            if (side_d) exp_d.push_back(e);
            else        exp_i.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            #2;
            ok = !(m_read && m_write) && !(i_grant && d_grant) &&
                 ((m_read || m_write) == (i_grant || d_grant)) && (!i_grant || m_read);
            check("invariant", 64'(ok), 64'd1);
            if (i_valid) begin
                i_vcnt++;
                if (exp_i.size() == 0) begin
                    check("i_extra_word", 64'(exp_i.size()), 64'd1);
                end else begin
                    e = exp_i.pop_front();
                    check("i_idx", 64'(i_idx), 64'(e.idx));
                    check("i_rdata", 64'(i_rdata), 64'(e.data));
                    check("i_maddr", 64'(m_addr), 64'(e.addr));
                end
            end
            if (d_valid) begin
                d_vcnt++;
                if (exp_d.size() == 0) begin
                    check("d_extra_word", 64'(exp_d.size()), 64'd1);
                end else begin
                    e = exp_d.pop_front();
                    check("d_idx", 64'(d_idx), 64'(e.idx));
                    check("d_maddr", 64'(m_addr), 64'(e.addr));
                    if (e.wr) check("d_wr", 64'({m_write, m_wdata}), 64'({1'b1, e.data}));
                    else      check("d_rdata", 64'({m_read, d_rdata}), 64'({1'b1, e.data}));
                end
            end
            if (i_done) begin
                i_dcnt++;
                done_log.push_back(1'b0);
                check("i_done_quiet", 64'({i_grant, m_read, m_write}), 64'd0);
            end
            if (d_done) begin
                d_dcnt++;
                done_log.push_back(1'b1);
                check("d_done_quiet", 64'({d_grant, m_read, m_write}), 64'd0);
            end
        end
    endtask

    function automatic int sel(input int which);
        case (which)
            0:       return i_dcnt;
            1:       return d_dcnt;
            2:       return i_vcnt;
            default: return done_log.size();
        endcase
    endfunction

    // Bounded wait for a counter to reach target; returns at negedge+3.
    task automatic wait_cnt(input string tag, input int which, input int target);
        int c;
        c = sel(which);
        for (int n = 0; n < 300 && c < target; n++) begin
            @(negedge clk);
            #3;
            c = sel(which);
        end
        check(tag, 64'(c), 64'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 64'({i_grant, i_valid, i_done, d_grant, d_valid, d_done,
                                    m_read, m_write, i_idx, d_idx}), 64'd0);
        check({tag, "_rdata"}, {32'd0, i_rdata, d_rdata}, 64'd0);
        check({tag, "_mem"}, {32'd0, m_addr, m_wdata}, 64'd0);
    endtask

    initial begin
        int v0, c0;
        for (int a = 0; a < 256; a++) img[a] = 16'hB000 + 16'(a * 7);
        fork
            monitor();
        join_none

        // reset state
        #1 reset_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // I-only refill, address inside the line
        lat = 2;
        push_line(1'b0, 1'b0, 16'h00A5);
        i_addr = 16'h00A5;
        i_req  = 1'b1;
        wait_cnt("i_refill_done", 0, 1);
        i_req = 1'b0;
        check("i_refill_words", 64'(exp_i.size()), 64'd0);
        repeat (3) @(negedge clk);
        #3 check("i_refill_one_done", 64'(i_dcnt), 64'd1);

        // D writeback, then an immediate read-back with zero latency so the
        // previous word's sticky handshake is present on the first cycle
        lat = 1;
        push_line(1'b1, 1'b1, 16'h0012);
        d_addr = 16'h0012;
        d_we   = 1'b1;
        d_req  = 1'b1;
        wait_cnt("d_wb_done", 1, 1);
        d_we = 1'b0;
        lat  = 0;
        push_line(1'b1, 1'b0, 16'h0010);
        for (int k = 0; k < 4; k++)
            check("wb_mem", 64'(mem[8'h10 + k]), 64'(WDATA_BASE + W'(k)));
        wait_cnt("d_rd_done", 1, 2);
        d_req = 1'b0;
        check("d_words", 64'(exp_d.size()), 64'd0);

        // tie after reset: D, I, D
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        done_log.delete();
        lat = 1;
        push_line(1'b1, 1'b0, 16'h0082);
        push_line(1'b0, 1'b0, 16'h0041);
        push_line(1'b1, 1'b0, 16'h0082);
        i_addr = 16'h0041;
        d_addr = 16'h0082;
        i_req  = 1'b1;
        d_req  = 1'b1;
        reset_n = 1'b1;
        wait_cnt("tie_bursts", 3, 3);
        i_req = 1'b0;
        d_req = 1'b0;
        if (done_log.size() >= 3) begin
            check("tie_order", 64'({done_log[0], done_log[1], done_log[2]}), 64'b101);
        end
        check("tie_words", 64'(exp_i.size() + exp_d.size()), 64'd0);
        repeat (2) @(negedge clk);

        // asynchronous reset during word 2 of an I refill
        lat = 2;
        push_line(1'b0, 1'b0, 16'h0031);
        i_addr = 16'h0031;
        i_req  = 1'b1;
        v0 = i_vcnt;
        c0 = i_dcnt;
        wait_cnt("rst_two_words", 2, v0 + 2);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_all_zero("rst_mid");
        exp_i.delete();
        @(negedge clk);
        #3 check("rst_no_done", 64'(i_dcnt), 64'(c0));
        reset_n = 1'b1;
        push_line(1'b0, 1'b0, 16'h0031);
        wait_cnt("rst_restart_done", 0, c0 + 1);
        i_req = 1'b0;
        check("rst_restart_words", 64'(i_vcnt), 64'(v0 + 6));
        check("rst_queue", 64'(exp_i.size()), 64'd0);

        // request dropped after the first word
        push_line(1'b0, 1'b0, 16'h006B);
        i_addr = 16'h006B;
        i_req  = 1'b1;
        v0 = i_vcnt;
        c0 = i_dcnt;
        wait_cnt("drop_first_word", 2, v0 + 1);
        i_req = 1'b0;
        wait_cnt("drop_done", 0, c0 + 1);
        repeat (4) @(negedge clk);
        #3;
        check("drop_one_done", 64'(i_dcnt), 64'(c0 + 1));
        check("drop_words", 64'(i_vcnt), 64'(v0 + 4));
        check("drop_queue", 64'(exp_i.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
